i2c_cmd_arbiter: RTL

Shares the single I2C master command interface (IO_CONTROL_* / IO_ADDR / IO_WDATA / IO_RDATA) between NUM_REQ requester state machines, such as the power, sideband, mux and QSFP module sequencers.
Each requester issues the same pulse/complete command protocol it would use toward the master directly.
The arbiter latches the command, grants round-robin, forwards one command at a time, and routes completion and read data back to the owner.
A watchdog terminates commands the master never completes.

---
 rtl/i2c_cmd_arbiter_if.sv | 32 +++
 rtl/i2c_cmd_arbiter.sv | 105 ++++++++++
 2 files changed

// File: rtl/i2c_cmd_arbiter_if.sv
// i2c_cmd_arbiter_if: requester-side command ports and I2C master command port of the arbiter.
interface i2c_cmd_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]   req_pulse;
    logic [NUM_REQ-1:0]   req_rw;
    logic [8*NUM_REQ-1:0] req_id;
    logic [8*NUM_REQ-1:0] req_addr;
    logic [8*NUM_REQ-1:0] req_wdata;
    logic [NUM_REQ-1:0]   req_cmplt;
    logic [7:0]           req_rdata;
    logic                 req_timeout;
    logic [NUM_REQ-1:0]   req_overrun;
    logic [7:0]           dbg_cstate;
    logic                 IO_CONTROL_PULSE;
    logic                 IO_CONTROL_RW;
    logic [7:0]           IO_CONTROL_ID;
    logic [7:0]           IO_ADDR_ADDR;
    logic [7:0]           IO_WDATA_WDATA;
    logic [7:0]           IO_RDATA_RDATA;
    logic                 IO_CONTROL_CMPLT;
    modport master (
        input  req_pulse, req_rw, req_id, req_addr, req_wdata, IO_RDATA_RDATA, IO_CONTROL_CMPLT,
        output req_cmplt, req_rdata, req_timeout, req_overrun, dbg_cstate,
               IO_CONTROL_PULSE, IO_CONTROL_RW, IO_CONTROL_ID, IO_ADDR_ADDR, IO_WDATA_WDATA
    );
    modport slave (
        output req_pulse, req_rw, req_id, req_addr, req_wdata, IO_RDATA_RDATA, IO_CONTROL_CMPLT,
        input  req_cmplt, req_rdata, req_timeout, req_overrun, dbg_cstate,
               IO_CONTROL_PULSE, IO_CONTROL_RW, IO_CONTROL_ID, IO_ADDR_ADDR, IO_WDATA_WDATA
    );
endinterface

// File: rtl/i2c_cmd_arbiter.sv
// i2c_cmd_arbiter: round-robin sharing of one I2C master command port among NUM_REQ requesters,
// with per-requester command latching, completion routing and a watchdog on stalled commands.
module i2c_cmd_arbiter #(
    parameter int          NUM_REQ        = 4,
    parameter int unsigned TIMEOUT_CYCLES = 50000000,
    parameter string       SIMULATION     = "false"
) (
    input logic clk,
    input logic rst,
    i2c_cmd_arbiter_if.master bus
);
    localparam int W = $clog2(NUM_REQ);
    localparam logic [31:0] TMO = (SIMULATION == "true") ? 32'h400 : 32'(TIMEOUT_CYCLES);
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_ISSUE = 2'd1, ST_WAIT = 2'd2, ST_DONE = 2'd3} state_t;
    state_t state, state_nx;
    logic [NUM_REQ-1:0] pending, hold_rw, clr, take;
    logic [7:0] hold_id [NUM_REQ];
    logic [7:0] hold_addr [NUM_REQ];
    logic [7:0] hold_wdata [NUM_REQ];
    logic [W-1:0] rr, winner, pick, idx;
    logic [31:0] wdog;
    logic [7:0] rd;
    logic to;
    assign clr = {{(NUM_REQ-1){1'b0}}, state == ST_DONE} << winner;
    // a pulse landing on the owner's DONE cycle is a fresh command, not an overrun
    assign take = bus.req_pulse & (~pending | clr);
    assign bus.dbg_cstate = {6'd0, state};
    // descending scan so the smallest offset from rr is the last to win
    always_comb begin
        pick = rr;
        idx = rr;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = W'((int'(rr) + i) % NUM_REQ);
            if (pending[idx]) pick = idx;
        end
    end
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:  state_nx = |pending ? ST_ISSUE : ST_IDLE;
            ST_ISSUE: state_nx = ST_WAIT;
            ST_WAIT:  state_nx = (bus.IO_CONTROL_CMPLT || wdog <= 32'd1) ? ST_DONE : ST_WAIT;
            default:  state_nx = ST_IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            pending <= '0;
            rr <= '0;
            winner <= '0;
            wdog <= '0;
            rd <= '0;
            to <= 1'b0;
            bus.req_cmplt <= '0;
            bus.req_rdata <= '0;
            bus.req_timeout <= 1'b0;
            bus.req_overrun <= '0;
            bus.IO_CONTROL_PULSE <= 1'b0;
            bus.IO_CONTROL_RW <= 1'b0;
            bus.IO_CONTROL_ID <= '0;
            bus.IO_ADDR_ADDR <= '0;
            bus.IO_WDATA_WDATA <= '0;
        end else begin
            state <= state_nx;
            pending <= (pending & ~clr) | take;
            bus.req_overrun <= bus.req_overrun | (bus.req_pulse & ~take);
            bus.IO_CONTROL_PULSE <= state == ST_IDLE && |pending;
            if (state == ST_IDLE && |pending) begin
                winner <= pick;
                bus.IO_CONTROL_RW <= hold_rw[pick];
                bus.IO_CONTROL_ID <= hold_id[pick];
                bus.IO_ADDR_ADDR <= hold_addr[pick];
                bus.IO_WDATA_WDATA <= hold_wdata[pick];
            end
            if (state == ST_ISSUE) wdog <= TMO;
            if (state == ST_WAIT) begin
                wdog <= wdog - 32'd1;
                rd <= bus.IO_CONTROL_CMPLT ? bus.IO_RDATA_RDATA : 8'hFF;
                to <= !bus.IO_CONTROL_CMPLT;
            end
            bus.req_cmplt <= clr;
            bus.req_timeout <= state == ST_DONE && to;
            if (state == ST_DONE) begin
                bus.req_rdata <= rd;
                rr <= (winner == W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
            end
        end
    end
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (rst) begin
                hold_rw[i] <= 1'b0;
                hold_id[i] <= '0;
                hold_addr[i] <= '0;
                hold_wdata[i] <= '0;
            end else if (take[i]) begin
                hold_rw[i] <= bus.req_rw[i];
                hold_id[i] <= bus.req_id[8*i +: 8];
                hold_addr[i] <= bus.req_addr[8*i +: 8];
                hold_wdata[i] <= bus.req_wdata[8*i +: 8];
            end
        end
    end
endmodule
